// File: rtl/uart_echo_buffer.sv
// UART echo buffer: DEPTH-entry FIFO between rx and tx handshakes, with pass and line release modes.
// Latency: 1 edge from FIFO write to the output register. Backpressure: rx_ready drops when full or flushing. Optional CR->CRLF via ECHO_CRLF_EN.
module uart_echo_buffer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] LINE_CHAR  = DATA_WIDTH'(8'h0D)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        line_mode,
    input  logic                        flush,
    input  logic                        rx_valid,
    input  logic [DATA_WIDTH-1:0]       rx_byte,
    output logic                        rx_ready,
    output logic [DATA_WIDTH-1:0]       tx_byte,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int              AW   = $clog2(DEPTH);
    localparam int              CW   = AW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         pending_q, pending_d;
    logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic                  tx_valid_q, tx_valid_d;

    logic push, pop, ins, out_free, release_ok, push_lc, pop_lc;
    logic [DATA_WIDTH-1:0] head;

`ifdef ECHO_CRLF_EN
    localparam logic [DATA_WIDTH-1:0] CR = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] LF = DATA_WIDTH'(8'h0A);
    logic lf_pend_q, lf_pend_d;
`endif

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        rx_ready   = (count_q != FULL) && !flush;
        push       = rx_valid && rx_ready;
        // A full FIFO must release even without a terminator, otherwise line mode deadlocks.
        release_ok = !line_mode || (pending_q != '0) || (count_q == FULL);
        out_free   = !tx_valid_q || tx_ready;
`ifdef ECHO_CRLF_EN
        ins        = lf_pend_q && out_free && !flush;
`else
        ins        = 1'b0;
`endif
        pop        = out_free && (count_q != '0) && release_ok && !flush && !ins;
        push_lc    = push && (rx_byte == LINE_CHAR);
        pop_lc     = pop && (head == LINE_CHAR);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pending_d  = pending_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pending_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (push_lc && !pop_lc)      pending_d = pending_q + CW'(1);
            else if (pop_lc && !push_lc) pending_d = pending_q - CW'(1);
        end

        if (ins) begin
`ifdef ECHO_CRLF_EN
            tx_byte_d  = LF;
`endif
            tx_valid_d = 1'b1;
        end else if (pop) begin
            tx_byte_d  = head;
            tx_valid_d = 1'b1;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

`ifdef ECHO_CRLF_EN
    // The LF is owed from the moment a CR leaves; set wins since a CR cannot leave while an LF is owed.
    always_comb begin
        lf_pend_d = lf_pend_q;
        if (tx_valid_q && tx_ready && (tx_byte_q == CR)) lf_pend_d = 1'b1;
        else if (ins)                                    lf_pend_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lf_pend_q <= 1'b0;
        else       lf_pend_q <= lf_pend_d;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= rx_byte;
    end

    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign count    = count_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: scoreboard of expected tx bytes, immediate-assertion checks.
module tb_uart_echo_buffer;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       line_mode;
    logic       flush;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [4:0] count;

    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    int         checks   = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    uart_echo_buffer #(.DATA_WIDTH(8), .DEPTH(DEPTH), .LINE_CHAR(8'h0D)) dut (
        .clock     (clock),
        .reset     (reset),
        .line_mode (line_mode),
        .flush     (flush),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_ready  (rx_ready),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs only change #1 after a rising edge, so a negedge handshake view is the next edge's transfer.
    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            chk("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                chk("tx_byte_order", {24'd0, tx_byte}, {24'd0, exp_b});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        k        = 0;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clock);
        while (!rx_ready && k < 200) begin
            k++;
            @(negedge clock);
        end
        if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        else begin
            exp_q.push_back(b);
`ifdef ECHO_CRLF_EN
            if (b == 8'h0D) exp_q.push_back(8'h0A);
`endif
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int k;
        k = 0;
        while ((count != 0 || tx_valid) && k < 300) begin
            k++;
            tick(1);
        end
        chk({tag, "_drain_count"}, {27'd0, count}, 32'd0);
        chk({tag, "_drain_txv"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset     = 1'b1;
        line_mode = 1'b0;
        flush     = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        tx_ready  = 1'b1;
        tick(2);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_txbyte", {24'd0, tx_byte}, 32'd0);
        reset = 1'b0;
        tick(1);
        chk("rst_rxrdy", {31'd0, rx_ready}, 32'd1);

        // Pass mode, back-to-back with latency check
        send(8'h41);
        chk("p_count1", {27'd0, count}, 32'd1);
        chk("p_lat_txv0", {31'd0, tx_valid}, 32'd0);
        send(8'h42);
        chk("p_lat_txv1", {31'd0, tx_valid}, 32'd1);
        chk("p_lat_byte", {24'd0, tx_byte}, 32'h41);
        chk("p_count2", {27'd0, count}, 32'd1);
        send(8'h43);
        chk("p_count3", {27'd0, count}, 32'd1);
        chk("p_byte2", {24'd0, tx_byte}, 32'h42);
        wait_empty("pass");

        // Line mode: hold until terminator
        line_mode = 1'b1;
        send(8'h68);
        send(8'h69);
        tick(3);
        chk("l_hold_txv", {31'd0, tx_valid}, 32'd0);
        chk("l_hold_count", {27'd0, count}, 32'd2);
        send(8'h0D);
        wait_empty("line");
        send(8'h41);
        tick(3);
        chk("l_pend0_txv", {31'd0, tx_valid}, 32'd0);
        chk("l_pend0_count", {27'd0, count}, 32'd1);

        // Flush with 3 held bytes
        send(8'h42);
        send(8'h43);
        chk("f_count3", {27'd0, count}, 32'd3);
        flush = 1'b1;
        @(negedge clock);
        chk("f_rxrdy", {31'd0, rx_ready}, 32'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        repeat (3) void'(exp_q.pop_back());
        chk("f_count0", {27'd0, count}, 32'd0);
        tick(3);
        chk("f_txv", {31'd0, tx_valid}, 32'd0);
        send(8'h0D);
        wait_empty("flush");

        // Fill with tx stalled: 16 in FIFO + 1 in output register
        line_mode = 1'b0;
        tx_ready  = 1'b0;
        for (int i = 0; i < 17; i++) send(8'h80 + 8'(i));
        chk("full_count", {27'd0, count}, 32'd16);
        chk("full_rxrdy", {31'd0, rx_ready}, 32'd0);
        chk("full_txv", {31'd0, tx_valid}, 32'd1);
        chk("full_txbyte", {24'd0, tx_byte}, 32'h80);
        tx_ready = 1'b1;
        wait_empty("full");

        // Line mode, full without terminator: forced release
        line_mode = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        tick(4);
        chk("force_count", {27'd0, count}, 32'd15);
        chk("force_rxrdy", {31'd0, rx_ready}, 32'd1);
        chk("force_txv", {31'd0, tx_valid}, 32'd0);
        send(8'h55);
        tick(3);
        chk("force_count2", {27'd0, count}, 32'd15);
        send(8'h0D);
        wait_empty("force");

        // CR followed by a byte in pass mode
        line_mode = 1'b0;
        send(8'h0D);
        send(8'h41);
        wait_empty("crlf");

        // Reset mid-transfer discards output register and FIFO
        tx_ready = 1'b0;
        send(8'h21);
        send(8'h22);
        tick(1);
        chk("mrst_txv_pre", {31'd0, tx_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst_txv", {31'd0, tx_valid}, 32'd0);
        chk("mrst_count", {27'd0, count}, 32'd0);
        chk("mrst_txbyte", {24'd0, tx_byte}, 32'd0);
        exp_q.delete();
        tick(1);
        reset    = 1'b0;
        tx_ready = 1'b1;
        tick(1);
        chk("mrst_rxrdy", {31'd0, rx_ready}, 32'd1);
        send(8'h33);
        wait_empty("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
